bus_source_reg: RTL

//   Registered, parametrised internal-bus source selector for the datapath.

---
 rtl/bus_source_if.sv | 30 +++
 rtl/bus_source_reg.sv | 104 ++++++++++
 2 files changed

// File: rtl/bus_source_if.sv
// Internal datapath bus bundle: source enables/words in, one registered bus word
// plus conflict status out.
interface bus_source_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 24,
    parameter int unsigned SELW  = 5,
    parameter int unsigned CNTW  = 8
);
    logic [NSRC-1:0]       src_en;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  sink_ready;
    logic                  conflict_clr;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SELW-1:0]       bus_src;
    logic                  conflict;
    logic [CNTW-1:0]       conflict_cnt;

    // Driver side: sources, consumer handshake and conflict clear.
    modport master (
        output src_en, src_data, sink_ready, conflict_clr,
        input  bus_out, bus_valid, bus_src, conflict, conflict_cnt
    );

    // Selector side.
    modport slave (
        input  src_en, src_data, sink_ready, conflict_clr,
        output bus_out, bus_valid, bus_src, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_source_reg.sv
// Registered one-hot bus source selector with valid/ready flow control and
// sticky, saturating multi-driver conflict detection.
module bus_source_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NSRC      = 24,
    parameter int unsigned SELW      = 5,
    parameter int unsigned HOLD_IDLE = 1,
    parameter int unsigned CNTW      = 8
) (
    input  logic        clock,
    input  logic        clear,
    bus_source_if.slave bus
);
    localparam int unsigned PCW = $clog2(NSRC + 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [PCW-1:0]   sel_cnt_c;
    logic [SELW-1:0]  sel_idx_c;
    logic [WIDTH-1:0] sel_word_c;
    logic             one_hot_c;
    logic             multi_c;
    logic             load_c;

    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic [SELW-1:0]  bus_src_q, bus_src_d;
    logic             conflict_q, conflict_d;
    logic [CNTW-1:0]  conflict_cnt_q, conflict_cnt_d;

    // Priority-free decode: OR together index and word of every enabled source;
    // the result is only used when exactly one enable is set.
    always_comb begin
        sel_cnt_c  = '0;
        sel_idx_c  = '0;
        sel_word_c = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.src_en[i]) begin
                sel_cnt_c  = sel_cnt_c + PCW'(1);
                sel_idx_c  = sel_idx_c | SELW'(i);
                sel_word_c = sel_word_c | bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign one_hot_c = (sel_cnt_c == PCW'(1));
    assign multi_c   = (sel_cnt_c > PCW'(1));
    assign load_c    = !bus_valid_q || bus.sink_ready;

    // Bus word / valid / source index update.
    always_comb begin
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        bus_src_d   = bus_src_q;
        if (load_c) begin
            bus_valid_d = 1'b0;
            if (one_hot_c) begin
                bus_out_d   = sel_word_c;
                bus_src_d   = sel_idx_c;
                bus_valid_d = 1'b1;
            end else if (!multi_c && (HOLD_IDLE == 0)) begin
                bus_out_d = '0;
            end
        end
    end

    // Conflict tracking runs every cycle; a same-cycle conflict beats the clear.
    always_comb begin
        conflict_d     = conflict_q;
        conflict_cnt_d = conflict_cnt_q;
        if (multi_c) begin
            conflict_d = 1'b1;
            if (bus.conflict_clr) begin
                conflict_cnt_d = CNTW'(1);
            end else if (conflict_cnt_q != CNT_MAX) begin
                conflict_cnt_d = conflict_cnt_q + CNTW'(1);
            end
        end else if (bus.conflict_clr) begin
            conflict_d     = 1'b0;
            conflict_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out_q      <= '0;
            bus_valid_q    <= 1'b0;
            bus_src_q      <= '0;
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            bus_out_q      <= bus_out_d;
            bus_valid_q    <= bus_valid_d;
            bus_src_q      <= bus_src_d;
            conflict_q     <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.bus_out      = bus_out_q;
    assign bus.bus_valid    = bus_valid_q;
    assign bus.bus_src      = bus_src_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule
